// File: rtl/pipeline_hazard_ctrl.sv
// Hazard unit for a 5-stage MIPS-style pipeline: EX forwarding, load-use and HI/LO stalls, redirect flushes, event counters.
// Optional multi-cycle mult/div tracking is built only when HAZARD_MULDIV_EN is defined.
module pipeline_hazard_ctrl #(
  parameter int unsigned MULDIV_LAT = 8
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [4:0]  RsD,
  input  logic [4:0]  RtD,
  input  logic [4:0]  RsE,
  input  logic [4:0]  RtE,
  input  logic [4:0]  WriteRegE,
  input  logic [4:0]  WriteRegM,
  input  logic [4:0]  WriteRegW,
  input  logic        RegWriteE,
  input  logic        RegWriteM,
  input  logic        RegWriteW,
  input  logic        MemtoRegE,
  input  logic        BranchTakenE,
  input  logic        JumpE,
  input  logic        JumpRegE,
  input  logic        MulDivStartE,
  input  logic        HiLoUseD,
  output logic        StallF,
  output logic        StallD,
  output logic        FlushD,
  output logic        FlushE,
  output logic [1:0]  ForwardAE,
  output logic [1:0]  ForwardBE,
  output logic        MulDivBusy,
  output logic        MulDivDone,
  output logic [15:0] StallCycles,
  output logic [15:0] FlushEvents
);

  logic w_lwstall;
  logic w_mdstall;
  logic w_redirect;
  logic w_stall;
  logic w_unused;

  // MEM result is younger than WB, so it wins when both target the same register.
  always_comb begin
    ForwardAE = 2'b00;
    ForwardBE = 2'b00;
    if (RegWriteM && (WriteRegM != 5'd0) && (WriteRegM == RsE))
      ForwardAE = 2'b10;
    else if (RegWriteW && (WriteRegW != 5'd0) && (WriteRegW == RsE))
      ForwardAE = 2'b01;
    if (RegWriteM && (WriteRegM != 5'd0) && (WriteRegM == RtE))
      ForwardBE = 2'b10;
    else if (RegWriteW && (WriteRegW != 5'd0) && (WriteRegW == RtE))
      ForwardBE = 2'b01;
  end

  assign w_lwstall  = MemtoRegE && (WriteRegE != 5'd0) &&
                      ((WriteRegE == RsD) || (WriteRegE == RtD));
  assign w_redirect = BranchTakenE | JumpE | JumpRegE;
  assign w_stall    = w_lwstall | w_mdstall;

  // A redirect kills the stalled ID instruction anyway, so fetch must not freeze.
  assign StallF = w_stall & ~w_redirect;
  assign StallD = w_stall & ~w_redirect;
  assign FlushD = w_redirect;
  assign FlushE = w_redirect | w_stall;

`ifdef HAZARD_MULDIV_EN
  typedef enum logic {S_IDLE = 1'b0, S_BUSY = 1'b1} state_t;

  localparam logic [7:0] LP_LOAD = 8'(MULDIV_LAT - 1);

  state_t     r_state;
  logic [7:0] r_count;

  // Redirects do not touch the FSM: the unit finishes whatever it started.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_count <= 8'd0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (MulDivStartE) begin
            r_state <= S_BUSY;
            r_count <= LP_LOAD;
          end
        end
        S_BUSY: begin
          if (r_count == 8'd0) r_state <= S_IDLE;
          else                 r_count <= r_count - 8'd1;
        end
        default: begin
          r_state <= S_IDLE;
          r_count <= 8'd0;
        end
      endcase
    end
  end

  assign MulDivBusy = (r_state == S_BUSY);
  assign MulDivDone = (r_state == S_BUSY) && (r_count == 8'd0);
  assign w_mdstall  = MulDivBusy & HiLoUseD;
  assign w_unused   = RegWriteE;
`else
  assign MulDivBusy = 1'b0;
  assign MulDivDone = 1'b0;
  assign w_mdstall  = 1'b0;
  assign w_unused   = ^{MulDivStartE, HiLoUseD, RegWriteE};
`endif

  logic [15:0] r_stall_cycles;
  logic [15:0] r_flush_events;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_stall_cycles <= 16'd0;
      r_flush_events <= 16'd0;
    end else begin
      if (StallD && (r_stall_cycles != 16'hFFFF))
        r_stall_cycles <= r_stall_cycles + 16'd1;
      if (w_redirect && (r_flush_events != 16'hFFFF))
        r_flush_events <= r_flush_events + 16'd1;
    end
  end

  assign StallCycles = r_stall_cycles;
  assign FlushEvents = r_flush_events;

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Directed bench for pipeline_hazard_ctrl; mult/div expectations follow whether HAZARD_MULDIV_EN is defined.
module tb_pipeline_hazard_ctrl;

`ifdef HAZARD_MULDIV_EN
  localparam bit MD = 1'b1;
`else
  localparam bit MD = 1'b0;
`endif

  logic        clk;
  logic        rst_n;
  logic [4:0]  RsD, RtD, RsE, RtE, WriteRegE, WriteRegM, WriteRegW;
  logic        RegWriteE, RegWriteM, RegWriteW, MemtoRegE;
  logic        BranchTakenE, JumpE, JumpRegE, MulDivStartE, HiLoUseD;
  logic        StallF, StallD, FlushD, FlushE, MulDivBusy, MulDivDone;
  logic [1:0]  ForwardAE, ForwardBE;
  logic [15:0] StallCycles, FlushEvents;

  int unsigned checks = 0;
  int unsigned errors = 0;
  logic [9:0]  exp_q[$];
  logic [15:0] exp_stalls = 16'd0;
  logic [15:0] exp_flushes = 16'd0;

  pipeline_hazard_ctrl #(.MULDIV_LAT(8)) dut (
    .clk(clk), .rst_n(rst_n),
    .RsD(RsD), .RtD(RtD), .RsE(RsE), .RtE(RtE),
    .WriteRegE(WriteRegE), .WriteRegM(WriteRegM), .WriteRegW(WriteRegW),
    .RegWriteE(RegWriteE), .RegWriteM(RegWriteM), .RegWriteW(RegWriteW),
    .MemtoRegE(MemtoRegE), .BranchTakenE(BranchTakenE), .JumpE(JumpE),
    .JumpRegE(JumpRegE), .MulDivStartE(MulDivStartE), .HiLoUseD(HiLoUseD),
    .StallF(StallF), .StallD(StallD), .FlushD(FlushD), .FlushE(FlushE),
    .ForwardAE(ForwardAE), .ForwardBE(ForwardBE),
    .MulDivBusy(MulDivBusy), .MulDivDone(MulDivDone),
    .StallCycles(StallCycles), .FlushEvents(FlushEvents)
  );

  // Clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [15:0] sat_inc(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  // Expected packing: {StallF,StallD,FlushD,FlushE,ForwardAE,ForwardBE,MulDivBusy,MulDivDone}
  function automatic logic [9:0] busy_exp(input bit stall, input bit redirect, input bit done);
    logic [9:0] e;
    e = 10'b0;
    if (redirect) e[7:6] = 2'b11;
    else if (stall && MD) e[9:6] = 4'b1101;
    e[1] = MD;
    e[0] = MD & done;
    return e;
  endfunction

  task automatic check16(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic clear_inputs();
    RsD = 0; RtD = 0; RsE = 0; RtE = 0;
    WriteRegE = 0; WriteRegM = 0; WriteRegW = 0;
    RegWriteE = 0; RegWriteM = 0; RegWriteW = 0; MemtoRegE = 0;
    BranchTakenE = 0; JumpE = 0; JumpRegE = 0;
    MulDivStartE = 0; HiLoUseD = 0;
  endtask

  // Driver: inputs already applied at negedge; check outputs, then advance one cycle.
  task automatic step(input string tag, input logic [9:0] exp);
    logic [9:0] obs;
    logic [9:0] e;
    exp_q.push_back(exp);
    #1;
    obs = {StallF, StallD, FlushD, FlushE, ForwardAE, ForwardBE, MulDivBusy, MulDivDone};
    e = exp_q.pop_front();
    checks++;
    assert (obs === e) else begin
      errors++;
      $error("FAIL %s: observed %b expected %b", tag, obs, e);
    end
    check16({tag, "_stallcnt"}, StallCycles, exp_stalls);
    check16({tag, "_flushcnt"}, FlushEvents, exp_flushes);
    @(posedge clk);
    if (rst_n) begin
      if (e[8]) exp_stalls = sat_inc(exp_stalls);
      if (e[7]) exp_flushes = sat_inc(exp_flushes);
    end
    @(negedge clk);
  endtask

  initial begin
    clear_inputs();
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    step("reset_idle", 10'b0);
    rst_n = 1'b1;

    // Forwarding
    RegWriteM = 1; WriteRegM = 5; RsE = 5; RegWriteW = 1; WriteRegW = 5;
    step("fwdA_mem_wins", 10'b0000_10_00_00);
    WriteRegM = 0;
    step("fwdA_wb", 10'b0000_01_00_00);
    WriteRegM = 9; RtE = 9; RsE = 3;
    step("fwdB_mem", 10'b0000_00_10_00);
    RegWriteM = 0; WriteRegW = 9;
    step("fwdB_wb", 10'b0000_00_01_00);
    RegWriteW = 0;
    step("fwdB_none", 10'b0);
    RegWriteM = 1; WriteRegM = 0; RsE = 0; RtE = 0;
    step("fwd_r0_never", 10'b0);
    clear_inputs();
    RsE = 12; RtE = 12; RegWriteM = 1; WriteRegM = 12;
    step("fwd_both_mem", 10'b0000_10_10_00);
    clear_inputs();

    // Load-use stall
    MemtoRegE = 1; WriteRegE = 7; RtD = 7;
    step("lwstall_rt", 10'b1101_00_00_00);
    RtD = 0; RsD = 7;
    step("lwstall_rs", 10'b1101_00_00_00);
    WriteRegE = 0; RsD = 0;
    step("lwstall_r0", 10'b0);
    WriteRegE = 7; RsD = 6; RtD = 8;
    step("lwstall_nomatch", 10'b0);
    RtD = 7; MemtoRegE = 0;
    step("lwstall_noload", 10'b0);

    // Redirect overrides stall
    MemtoRegE = 1; BranchTakenE = 1;
    step("lw_plus_branch", 10'b0011_00_00_00);
    clear_inputs(); JumpE = 1;
    step("jump", 10'b0011_00_00_00);
    clear_inputs(); JumpRegE = 1;
    step("jumpreg", 10'b0011_00_00_00);
    clear_inputs();

    // Mult/div: clean run
    MulDivStartE = 1; HiLoUseD = 1;
    step("md_start", 10'b0);
    MulDivStartE = 0;
    for (int i = 0; i < 7; i++) step("md_busy", busy_exp(1, 0, 0));
    step("md_done", busy_exp(1, 0, 1));
    step("md_after", 10'b0);

    // Mult/div: redirect mid-flight does not abort
    MulDivStartE = 1;
    step("md2_start", 10'b0);
    MulDivStartE = 0;
    step("md2_busy", busy_exp(1, 0, 0));
    BranchTakenE = 1; MulDivStartE = 1;
    step("md2_redirect", busy_exp(1, 1, 0));
    BranchTakenE = 0; MulDivStartE = 0;
    for (int i = 0; i < 5; i++) step("md2_busy", busy_exp(1, 0, 0));
    step("md2_done", busy_exp(1, 0, 1));
    step("md2_after", 10'b0);

    // Reset while busy
    MulDivStartE = 1;
    step("md3_start", 10'b0);
    MulDivStartE = 0;
    for (int i = 0; i < 3; i++) step("md3_busy", busy_exp(1, 0, 0));
    rst_n = 1'b0;
    exp_stalls = 16'd0;
    exp_flushes = 16'd0;
    MemtoRegE = 1; WriteRegE = 4; RsD = 4;
    for (int i = 0; i < 3; i++) step("rst_comb_live", 10'b1101_00_00_00);
    rst_n = 1'b1;
    MemtoRegE = 0;
    for (int i = 0; i < 10; i++) step("rst_no_done", 10'b0);
    clear_inputs();

    // Saturating stall counter
    MemtoRegE = 1; WriteRegE = 2 + 5'($urandom_range(0, 20)); RtD = WriteRegE;
    for (int i = 0; i < 70000; i++) begin
      @(posedge clk);
      exp_stalls = sat_inc(exp_stalls);
    end
    @(negedge clk);
    check16("stall_sat_value", StallCycles, 16'hFFFF);
    step("stall_sat_hold", 10'b1101_00_00_00);
    step("stall_sat_hold2", 10'b1101_00_00_00);
    clear_inputs();
    step("final_idle", 10'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
